boot_image_writer: RTL and testbench



---
 rtl/boot_image_writer_pkg.sv | 23 ++
 rtl/boot_image_writer_boot_init_seq.sv | 56 +++++
 rtl/boot_image_writer.sv | 132 +++++++++++++
 tb/tb_boot_image_writer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_image_writer_pkg.sv
// Shared encodings for the boot init sequencer and the loader word handshake.
// The SD-card loader decodes these same values, so they live in one place.
package boot_image_writer_pkg;

    // Boot sequencer states. Values 2 and 5-7 are never produced.
    typedef enum logic [2:0] {
        INIT_ST_RESET    = 3'd0,
        INIT_ST_WAIT_CAL = 3'd1,
        INIT_ST_LOAD     = 3'd3,
        INIT_ST_DONE     = 3'd4
    } init_st_e;

    // Loader-facing handshake states. Zero means "ready for a word".
    typedef enum logic [7:0] {
        CTRL_IDLE    = 8'd0,
        CTRL_REQ     = 8'd1,
        CTRL_WAIT_WE = 8'd2
    } ctrl_st_e;

    // Each image word occupies four bytes of main memory.
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/boot_image_writer_boot_init_seq.sv
// Boot init sequencer: waits for memory calibration, opens the load window
// for the SD-card loader and releases the CPU once the image is in memory.
module boot_init_seq
    import boot_image_writer_pkg::*;
(
    input  logic     clk27mhz,
    input  logic     reset,
    input  logic     calib_i,
    input  logic     ld_done_i,
    input  logic     ctrl_idle_i,
    output init_st_e main_init_state_o,
    output logic     boot_release_o
);

    init_st_e state_q;
    logic     release_q;

    // Sequencer with boot_release registered alongside the DONE transition,
    // so both become visible in the same cycle.
    always_ff @(posedge clk27mhz) begin
        if (reset) begin
            state_q   <= INIT_ST_RESET;
            release_q <= 1'b0;
        end else begin
            case (state_q)
                INIT_ST_RESET: begin
                    state_q <= INIT_ST_WAIT_CAL;
                end
                INIT_ST_WAIT_CAL: begin
                    // Once past here, calibration dropping is ignored.
                    if (calib_i) begin
                        state_q <= INIT_ST_LOAD;
                    end
                end
                INIT_ST_LOAD: begin
                    // A word still in flight must finish before DONE.
                    if (ld_done_i && ctrl_idle_i) begin
                        state_q   <= INIT_ST_DONE;
                        release_q <= 1'b1;
                    end
                end
                INIT_ST_DONE: begin
                    state_q <= INIT_ST_DONE;
                end
                default: begin
                    state_q   <= INIT_ST_RESET;
                    release_q <= 1'b0;
                end
            endcase
        end
    end

    assign main_init_state_o = state_q;
    assign boot_release_o    = release_q;

endmodule

// File: rtl/boot_image_writer.sv
// Boot image writer: takes the SD-card loader's word stream through the
// WE/ctrl_state handshake and writes each word to main memory at an
// incrementing byte address over a req/ack port. Keeps a saturating word
// count, a running modulo-2^32 checksum and a sticky overflow flag.
module boot_image_writer
    import boot_image_writer_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [31:0]        MAX_WORDS = 32'h0004_0000
) (
    input  logic              clk27mhz,
    input  logic              reset,
    input  logic              mem_calib_done,
    input  logic [31:0]       ld_data,
    input  logic              ld_we,
    input  logic              ld_done,
    output logic [7:0]        ctrl_state,
    output logic [2:0]        main_init_state,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              boot_release,
    output logic [31:0]       word_count,
    output logic [31:0]       checksum,
    output logic              overflow
);

    // Word count stops at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    ctrl_st_e          ctrl_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       count_q;
    logic [31:0]       sum_q;
    logic              ovf_q;

    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       count_d;
    logic [31:0]       sum_d;

    init_st_e          init_st;
    logic              release_w;
    logic              load_active;
    logic              can_write;

    boot_init_seq u_init_seq (
        .clk27mhz          (clk27mhz),
        .reset             (reset),
        .calib_i           (mem_calib_done),
        .ld_done_i         (ld_done),
        .ctrl_idle_i       (ctrl_q == CTRL_IDLE),
        .main_init_state_o (init_st),
        .boot_release_o    (release_w)
    );

    // Post-ack bookkeeping values; the address wraps at 2^ADDR_W naturally.
    always_comb begin
        addr_d      = addr_q + ADDR_W'(WORD_BYTES);
        count_d     = sat_inc32(count_q);
        sum_d       = sum_q + wdata_q;
        load_active = (init_st == INIT_ST_LOAD);
        can_write   = (count_q < MAX_WORDS);
    end

    // Word handshake FSM. ctrl_state never returns to IDLE while ld_we is
    // high, so a word held by the loader is captured exactly once.
    always_ff @(posedge clk27mhz) begin
        if (reset) begin
            ctrl_q  <= CTRL_IDLE;
            req_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            count_q <= 32'd0;
            sum_q   <= 32'd0;
            ovf_q   <= 1'b0;
        end else begin
            case (ctrl_q)
                CTRL_IDLE: begin
                    // Writes outside the load window are ignored.
                    if (load_active && ld_we) begin
                        wdata_q <= ld_data;
                        if (can_write) begin
                            req_q  <= 1'b1;
                            ctrl_q <= CTRL_REQ;
                        end else begin
                            // Drop the word but still cycle the handshake so
                            // the loader keeps moving.
                            ovf_q  <= 1'b1;
                            ctrl_q <= CTRL_WAIT_WE;
                        end
                    end
                end
                CTRL_REQ: begin
                    // Address and data held stable until memory accepts.
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        count_q <= count_d;
                        sum_q   <= sum_d;
                        addr_q  <= addr_d;
                        ctrl_q  <= ld_we ? CTRL_WAIT_WE : CTRL_IDLE;
                    end
                end
                CTRL_WAIT_WE: begin
                    if (!ld_we) begin
                        ctrl_q <= CTRL_IDLE;
                    end
                end
                default: begin
                    req_q  <= 1'b0;
                    ctrl_q <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign ctrl_state      = ctrl_q;
    assign main_init_state = init_st;
    assign mem_req         = req_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign boot_release    = release_w;
    assign word_count      = count_q;
    assign checksum        = sum_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_boot_image_writer.sv
// Testbench for boot_image_writer: randomized loader traffic, a memory
// responder that compares every accepted write against a queue of expected
// writes, and a reference model of count/checksum/address arithmetic.
module tb_boot_image_writer;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;   // wraps after two words
    localparam int unsigned MAXW = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk27mhz = 1'b0;
    logic        reset;
    logic        mem_calib_done;
    logic [31:0] ld_data;
    logic        ld_we;
    logic        ld_done;
    logic [7:0]  ctrl_state;
    logic [2:0]  main_init_state;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        boot_release;
    logic [31:0] word_count;
    logic [31:0] checksum;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    int          writes   = 0;
    int          ack_delay = 2;
    bit          stray_ack = 1'b0;

    wr_t         exp_q[$];
    int unsigned m_count;
    logic [31:0] m_sum;
    logic        m_ovf;

    boot_image_writer #(
        .ADDR_W    (32),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk27mhz        (clk27mhz),
        .reset           (reset),
        .mem_calib_done  (mem_calib_done),
        .ld_data         (ld_data),
        .ld_we           (ld_we),
        .ld_done         (ld_done),
        .ctrl_state      (ctrl_state),
        .main_init_state (main_init_state),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .boot_release    (boot_release),
        .word_count      (word_count),
        .checksum        (checksum),
        .overflow        (overflow)
    );

    always #5 clk27mhz = ~clk27mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder and write monitor: acks after ack_delay cycles and
    // compares each accepted write with the head of the expected queue.
    initial begin
        int unsigned wait_cnt;
        logic [31:0] held_addr;
        logic [31:0] held_data;
        wr_t         e;
        mem_ack  = 1'b0;
        wait_cnt = 0;
        held_addr = '0;
        held_data = '0;
        forever begin
            @(negedge clk27mhz);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !reset) begin
                if (wait_cnt == 0) begin
                    held_addr = mem_addr;
                    held_data = mem_wdata;
                end else begin
                    check("req_addr_stable", mem_addr, held_addr);
                    check("req_data_stable", mem_wdata, held_data);
                end
                if (wait_cnt >= ack_delay) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", mem_addr, e.addr);
                        check("write_data", mem_wdata, e.data);
                    end
                    writes++;
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (stray_ack) begin
                    mem_ack   = 1'b1;
                    stray_ack = 1'b0;
                end
            end
        end
    end

    task automatic model_reset();
        m_count = 0;
        m_sum   = 32'd0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl_state"}, 32'(ctrl_state), 32'd0);
        check({tag, "_init_state"}, 32'(main_init_state), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, BASE);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_boot_release"}, 32'(boot_release), 32'd0);
        check({tag, "_word_count"}, word_count, 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk27mhz);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk27mhz);
        check_reset_values(tag);
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_word_count"}, word_count, m_count);
        check({tag, "_checksum"}, checksum, m_sum);
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_next_addr"}, mem_addr, BASE + 32'(m_count * 4));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        int n;
        n = 0;
        while (main_init_state != st && n < 20) begin
            @(negedge clk27mhz);
            n++;
        end
        check(tag, 32'(main_init_state), 32'(st));
    endtask

    // Loader model for one word: raise WE, drop it `hold` cycles after the
    // first busy ctrl_state, then wait for the handshake to return to ready.
    task automatic send_word(input logic [31:0] d, input int hold);
        int n;
        bit will_write;
        @(negedge clk27mhz);
        ld_data = d;
        ld_we   = 1'b1;
        will_write = (m_count < MAXW);
        if (will_write) begin
            exp_q.push_back('{addr: BASE + 32'(m_count * 4), data: d});
            m_count++;
            m_sum = m_sum + d;
        end else begin
            m_ovf = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk27mhz);
            n++;
        end while (ctrl_state == 8'd0 && n < 20);
        check("ctrl_first_busy", 32'(ctrl_state), will_write ? 32'd1 : 32'd2);
        if (!will_write) check("ovf_no_req", 32'(mem_req), 32'd0);
        repeat (hold) @(negedge clk27mhz);
        ld_we = 1'b0;
        n = 0;
        while (ctrl_state != 8'd0 && n < 60) begin
            @(negedge clk27mhz);
            n++;
        end
        check("ctrl_back_idle", 32'(ctrl_state), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        reset          = 1'b1;
        mem_calib_done = 1'b0;
        ld_data        = 32'd0;
        ld_we          = 1'b0;
        ld_done        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk27mhz);
        check_reset_values("rst0");
        reset = 1'b0;

        // Sequencer leaves RESET; loader writes during WAIT_CAL are ignored.
        @(negedge clk27mhz);
        check("wait_cal_state", 32'(main_init_state), 32'd1);
        ld_data = 32'hDEAD_BEEF;
        ld_we   = 1'b1;
        repeat (3) begin
            @(negedge clk27mhz);
            check("early_we_ctrl", 32'(ctrl_state), 32'd0);
            check("early_we_req", 32'(mem_req), 32'd0);
            check("early_we_state", 32'(main_init_state), 32'd1);
        end
        ld_we = 1'b0;
        mem_calib_done = 1'b1;
        @(negedge clk27mhz);
        check("load_state", 32'(main_init_state), 32'd3);
        check("load_ctrl", 32'(ctrl_state), 32'd0);
        check("load_req", 32'(mem_req), 32'd0);
        mem_calib_done = 1'b0;   // dropping calibration later is ignored

        // Four fixed words with ack two cycles after the request.
        ack_delay = 2;
        send_word(32'h1122_3344, 0);
        send_word(32'h5566_7788, 0);
        send_word(32'h0000_0001, 0);
        send_word(32'hFFFF_FFFF, 0);
        repeat (2) @(negedge clk27mhz);
        check_model("four_words");
        check("four_words_writes", 32'(writes), 32'd4);
        check("calib_drop_state", 32'(main_init_state), 32'd3);

        // A stray ack while idle changes nothing.
        stray_ack = 1'b1;
        repeat (3) @(negedge clk27mhz);
        check_model("stray_ack");
        check("stray_ack_ctrl", 32'(ctrl_state), 32'd0);

        // WE held five cycles past the ack: parked in WAIT_WE, one write only.
        w0 = writes;
        @(negedge clk27mhz);
        ld_data = 32'hA5A5_0F0F;
        ld_we   = 1'b1;
        exp_q.push_back('{addr: BASE + 32'(m_count * 4), data: 32'hA5A5_0F0F});
        m_count++;
        m_sum = m_sum + 32'hA5A5_0F0F;
        n = 0;
        do begin
            @(negedge clk27mhz);
            n++;
        end while (ctrl_state != 8'd2 && n < 20);
        check("hold_wait_we", 32'(ctrl_state), 32'd2);
        repeat (5) begin
            @(negedge clk27mhz);
            check("hold_stays_wait", 32'(ctrl_state), 32'd2);
        end
        ld_we = 1'b0;
        @(negedge clk27mhz);
        check("hold_release_idle", 32'(ctrl_state), 32'd0);
        check("hold_one_write", 32'(writes - w0), 32'd1);
        check_model("hold");

        // Random words until capacity, then two more that must be dropped.
        while (m_count < MAXW) begin
            ack_delay = $urandom_range(0, 4);
            send_word($urandom, $urandom_range(0, 3));
        end
        repeat (2) @(negedge clk27mhz);
        check_model("full");
        check("full_no_ovf", 32'(overflow), 32'd0);
        w0 = writes;
        send_word($urandom, 0);
        send_word($urandom, 2);
        repeat (2) @(negedge clk27mhz);
        check_model("overflow");
        check("overflow_no_write", 32'(writes - w0), 32'd0);

        // ld_done raised while a write waits ten cycles for its ack.
        do_reset("rst1");
        mem_calib_done = 1'b1;
        wait_state(3'd3, "reload_state");
        ack_delay = 10;
        @(negedge clk27mhz);
        ld_data = $urandom;
        ld_we   = 1'b1;
        exp_q.push_back('{addr: BASE, data: ld_data});
        m_count = 1;
        m_sum   = ld_data;
        @(negedge clk27mhz);
        check("done_req_ctrl", 32'(ctrl_state), 32'd1);
        ld_we   = 1'b0;
        ld_done = 1'b1;
        n = 0;
        while (ctrl_state != 8'd0 && n < 40) begin
            check("done_held_state", 32'(main_init_state), 32'd3);
            check("done_held_release", 32'(boot_release), 32'd0);
            @(negedge clk27mhz);
            n++;
        end
        check("done_after_ack_state", 32'(main_init_state), 32'd3);
        @(negedge clk27mhz);
        check("done_state", 32'(main_init_state), 32'd4);
        check("done_release", 32'(boot_release), 32'd1);
        check_model("done");

        // Reset from DONE brings everything back.
        ld_done = 1'b0;
        do_reset("rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
